// File: rtl/audio_pkg.sv
// Shared types, constants and the round-robin pick helper for the audio sample arbiter.
package audio_pkg;

  typedef enum logic {IDLE, PLAY} arb_state_t;

  localparam int SAMPLE_W = 16;
  localparam int MAX_REQ  = 8;

  // One-hot pick of the first eligible index searching upward from last+1 (mod n).
  // Scanning from the farthest offset down lets the nearest hit overwrite earlier ones.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] eligible,
    input logic [2:0]         last,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    int                 idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (eligible[idx[2:0]]) begin
          pick = '0;
          pick[idx[2:0]] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/audio_sample_arbiter_rr.sv
// Pure combinational round-robin selector; widens its inputs to the package helper's fixed size.
module rr_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [MAX_REQ-1:0] elig_wide;
  logic [MAX_REQ-1:0] pick_wide;
  logic [2:0]         last_wide;

  always_comb begin
    elig_wide                = '0;
    last_wide                = '0;
    elig_wide[NUM_REQ-1:0]   = eligible;
    last_wide[IDX_W-1:0]     = last;
    pick_wide                = rr_pick(elig_wide, last_wide, NUM_REQ);
  end

  assign pick = pick_wide[NUM_REQ-1:0];
  assign any  = |pick_wide;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/audio_sample_arbiter.sv
// Round-robin owner of the DAC sample path, paced by the serializer's per-frame ACK.
// Optional per-source attenuation is enabled with `define AUDIO_ARB_VOLUME_EN.
module audio_sample_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_FRAMES = 48000,
  parameter int CNT_W      = $clog2(MAX_FRAMES+1)
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [SAMPLE_W*NUM_REQ-1:0]  sample_data,
`ifdef AUDIO_ARB_VOLUME_EN
  input  logic [2*NUM_REQ-1:0]         vol,
`endif
  output logic [NUM_REQ-1:0]           sample_pop,
  output logic [NUM_REQ-1:0]           grant,
  input  logic                         DACDATA_ACK,
  output logic [SAMPLE_W-1:0]          DACDATA,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   mask_q, mask_d;
  logic [NUM_REQ-1:0]   pop_q, pop_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0]  dac_q, dac_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [SAMPLE_W-1:0]        samples [NUM_REQ];
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W-1:0]        loaded;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign samples[gi] = sample_data[SAMPLE_W*gi +: SAMPLE_W];
  end

`ifdef AUDIO_ARB_VOLUME_EN
  logic [1:0] vols [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_vol
    assign vols[gi] = vol[2*gi +: 2];
  end
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible (req & ~mask_q),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // last_q always names the current owner while in PLAY, so it doubles as the data mux select.
  always_comb begin
    cur_sample = samples[last_q];
`ifdef AUDIO_ARB_VOLUME_EN
    loaded = $unsigned(cur_sample >>> vols[last_q]);
`else
    loaded = $unsigned(cur_sample);
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    mask_d      = mask_q & req;
    dac_d       = dac_q;
    pop_d       = '0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (DACDATA_ACK) dac_d = '0;
        if (pick_any) begin
          grant_d     = pick;
          last_d      = pick_idx;
          frame_cnt_d = '0;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (!req[last_q]) begin
          if (DACDATA_ACK) dac_d = '0;
          grant_d = '0;
          state_d = IDLE;
        end else if (DACDATA_ACK) begin
          if (frame_cnt_q == CNT_W'(MAX_FRAMES-1)) begin
            dac_d          = '0;
            timeout_d      = 1'b1;
            mask_d[last_q] = 1'b1;
            grant_d        = '0;
            state_d        = IDLE;
          end else begin
            dac_d         = loaded;
            pop_d[last_q] = 1'b1;
            frame_cnt_d   = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      mask_q      <= '0;
      pop_q       <= '0;
      last_q      <= IDX_W'(NUM_REQ-1);
      frame_cnt_q <= '0;
      dac_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mask_q      <= mask_d;
      pop_q       <= pop_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
      dac_q       <= dac_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign sample_pop  = pop_q;
  assign DACDATA     = dac_q;
  assign busy        = (state_q == PLAY);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_audio_sample_arbiter.sv
// Directed self-checking bench for audio_sample_arbiter (NUM_REQ=4, MAX_FRAMES=4).
module tb_audio_sample_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int MAX_FRAMES = 4;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [16*NUM_REQ-1:0] sample_data = '0;
`ifdef AUDIO_ARB_VOLUME_EN
  logic [2*NUM_REQ-1:0] vol = '0;
`endif
  logic [NUM_REQ-1:0]   sample_pop;
  logic [NUM_REQ-1:0]   grant;
  logic                 DACDATA_ACK = 1'b0;
  logic [15:0]          DACDATA;
  logic                 busy;
  logic                 timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_sample_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MAX_FRAMES (MAX_FRAMES)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req         (req),
    .sample_data (sample_data),
`ifdef AUDIO_ARB_VOLUME_EN
    .vol         (vol),
`endif
    .sample_pop  (sample_pop),
    .grant       (grant),
    .DACDATA_ACK (DACDATA_ACK),
    .DACDATA     (DACDATA),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_ack();
    DACDATA_ACK = 1'b1;
    tick(1);
    DACDATA_ACK = 1'b0;
    $display("ack: DACDATA=%h pop=%b grant=%b timeout=%b", DACDATA, sample_pop, grant, timeout_err);
  endtask

  task automatic set_sample(input int idx, input logic [15:0] val);
    sample_data[16*idx +: 16] = val;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_dac", DACDATA, 0);
    check("rst_pop", sample_pop, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);

    // Idle frames: silence, no owner, no pops
    for (int k = 0; k < 3; k++) begin
      tick(3);
      do_ack();
      check("idle_dac", DACDATA, 0);
      check("idle_grant", grant, 0);
      check("idle_pop", sample_pop, 0);
    end

    // Two sources requesting: source 0 wins first, back-to-back ACKs both pop
    set_sample(0, 16'h1234);
    set_sample(2, 16'h8000);
    req = 4'b0101;
    tick(1);
    check("g0_grant", grant, 4'b0001);
    check("g0_busy", busy, 1);
    DACDATA_ACK = 1'b1;
    tick(1);
    check("g0_dac1", DACDATA, 16'h1234);
    check("g0_pop1", sample_pop, 4'b0001);
    tick(1);
    DACDATA_ACK = 1'b0;
    check("g0_dac2", DACDATA, 16'h1234);
    check("g0_pop2", sample_pop, 4'b0001);
    tick(1);
    check("g0_pop_end", sample_pop, 4'b0000);
    req = 4'b0100;
    tick(1);
    check("drop_grant", grant, 4'b0000);
    check("drop_dac_hold", DACDATA, 16'h1234);
    tick(1);
    check("g2_grant", grant, 4'b0100);
    tick(2);
    do_ack();
    check("g2_dac", DACDATA, 16'h8000);
    check("g2_pop", sample_pop, 4'b0100);
    req = 4'b0000;
    tick(1);
    check("g2_release", grant, 4'b0000);

    // Timeout: source 1 runs MAX_FRAMES-1 frames then is force-released and masked
    req = 4'b0010;
    tick(1);
    check("g1_grant", grant, 4'b0010);
    for (int k = 1; k <= 3; k++) begin
      set_sample(1, 16'(16'h0111 * k));
      tick(2);
      do_ack();
      check("to_dac", DACDATA, 16'h0111 * k);
      check("to_pop", sample_pop, 4'b0010);
      check("to_noerr", timeout_err, 0);
    end
    tick(2);
    do_ack();
    check("to4_dac", DACDATA, 0);
    check("to4_pop", sample_pop, 0);
    check("to4_err", timeout_err, 1);
    check("to4_grant", grant, 0);
    tick(1);
    check("to_err_pulse", timeout_err, 0);
    tick(2);
    do_ack();
    check("to5_dac", DACDATA, 0);
    check("to5_grant", grant, 0);
    tick(3);
    check("masked_grant", grant, 0);
    req = 4'b0000;
    tick(1);
    req = 4'b0010;
    tick(1);
    check("regrant", grant, 4'b0010);

    // ACK coinciding with the owner's request falling
    set_sample(1, 16'h5555);
    tick(2);
    do_ack();
    check("pre_fall_dac", DACDATA, 16'h5555);
    tick(2);
    req = 4'b0000;
    do_ack();
    check("fall_dac", DACDATA, 0);
    check("fall_pop", sample_pop, 0);
    check("fall_grant", grant, 0);
    check("fall_busy", busy, 0);

`ifdef AUDIO_ARB_VOLUME_EN
    vol = 8'b0000_0010;
    set_sample(0, 16'hF000);
    req = 4'b0001;
    tick(1);
    check("vol_grant", grant, 4'b0001);
    do_ack();
    check("vol_dac", DACDATA, 16'hFC00);
    req = 4'b0000;
    vol = '0;
    tick(2);
`endif

    // Reset mid-PLAY with an ACK pending on the same edge
    set_sample(0, 16'h1234);
    req = 4'b0001;
    tick(1);
    check("pre_rst_grant", grant, 4'b0001);
    do_ack();
    check("pre_rst_dac", DACDATA, 16'h1234);
    tick(2);
    reset = 1'b1;
    DACDATA_ACK = 1'b1;
    tick(1);
    reset = 1'b0;
    DACDATA_ACK = 1'b0;
    check("mid_rst_dac", DACDATA, 0);
    check("mid_rst_pop", sample_pop, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", timeout_err, 0);
    tick(1);
    check("post_rst_grant", grant, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_arbiter.md
# audio_sample_arbiter

Shares the single 16-bit DAC sample path between several sound-effect sources (ball hit, goal, whistle, ...) in the CLOCK_50 domain. Sits upstream of the DAC serializer. Its `DACDATA` output drives the serializer's parallel input, and the serializer's per-frame `DACDATA_ACK` pulse paces it. Sources are granted round-robin. Each grant is held for the whole sound, up to a frame limit. Silence (0) is output when no source is granted.

## Interface
- `NUM_REQ`, default 4: number of sound sources (2..8).
- `MAX_FRAMES`, default 48000: maximum frames one grant may hold.
- `CNT_W`, default $clog2(MAX_FRAMES+1): frame counter width.
- `CLOCK_50`  in  1  system clock. One clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-source request, level. Held high for the duration of the sound.
- `sample_data`  in  16*NUM_REQ  per-source signed sample. Source i uses bits [16i+15:16i].
- `sample_pop`  out  NUM_REQ  one-cycle pulse: source i's current sample was consumed; it must advance.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `DACDATA_ACK`  in  1  one-cycle pulse per audio frame from the serializer.
- `DACDATA`  out  16  sample presented for the next frame.
- `busy`  out  1  high while in PLAY.
- `timeout_err`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- Eligible set: `req & ~mask`. `mask[i]` is set on a timeout of source i. It clears on the first cycle `req[i]` is low.
- FSM states are IDLE and PLAY.
- IDLE:
  - If any source is eligible, pick the first eligible index searching upward (mod NUM_REQ) from `last+1`.
  - Register it into `grant` and `last`, clear `frame_cnt`, and go to PLAY.
  - The grant is visible one cycle after the request is seen.
- IDLE, ACK received: `DACDATA` <= 0 and no pop. This applies even on the same cycle a grant decision is made.
- PLAY, ACK received, granted `req[g]` high, `frame_cnt < MAX_FRAMES-1`:
  - `DACDATA` <= `sample_data[g]`.
  - `sample_pop[g]` pulses on the next cycle.
  - `frame_cnt` increments.
- PLAY, ACK received, `frame_cnt == MAX_FRAMES-1`:
  - `DACDATA` <= 0, no pop.
  - `timeout_err` pulses and `mask[g]` is set.
  - `grant` clears and the FSM goes to IDLE.
- PLAY, `req[g]` low:
  - `grant` clears next cycle and the FSM goes to IDLE. This happens without waiting for an ACK.
  - `DACDATA` holds its value until the next ACK loads 0 from IDLE.
- Requests from non-granted sources are never preempted and never popped.
- `sample_data` is sampled only on the ACK cycle. Sources must hold a sample stable from one pop until the next ACK.

## Timing
- Reset values: `grant`=0, `sample_pop`=0, `DACDATA`=0, `busy`=0, `timeout_err`=0, `mask`=0, `last`=NUM_REQ-1 (so source 0 wins first), `frame_cnt`=0, state IDLE.
- Reset asserted mid-PLAY: all of the above take effect on the next edge. No pop is issued and no timeout is flagged.
- Latency from ACK to `DACDATA` update: 1 cycle (registered).
- Latency from ACK to `sample_pop`: 1 cycle, the same edge as the `DACDATA` update.
- Latency from `req` rising (in IDLE) to `grant`: 1 cycle.
- Latency from `req[g]` falling to `grant`=0: 1 cycle.
- Back-to-back ACKs are at least one frame apart (≥1000 cycles). The block must still handle ACKs on consecutive cycles without missing a pop.
- If an ACK and a `req[g]` fall happen on the same cycle in PLAY, the ACK loads 0, no pop is issued, and the FSM goes to IDLE.

## Configuration
- `AUDIO_ARB_VOLUME_EN` defined:
  - Adds input port `vol`, 2*NUM_REQ bits.
  - The loaded sample is `sample_data[g] >>> vol[g]` (arithmetic, sign-preserving, 0..3 bit attenuation).
  - `vol` is sampled on the ACK cycle.
- `AUDIO_ARB_VOLUME_EN` undefined: the `vol` port is absent and samples pass through unchanged.

## Structure
- Package `audio_pkg`:
  - state enum `arb_state_t {IDLE, PLAY}`
  - `localparam SAMPLE_W = 16`
  - function `rr_pick(eligible, last)` returning the one-hot grant
- Sub-module `rr_arbiter`: pure round-robin selector, parameterised by NUM_REQ. The FSM, counter, mask and data path stay in `audio_sample_arbiter`.

## Test plan
- Reset, then `req`=0 and 3 ACKs: `DACDATA`=0 each frame, `grant`=0, no pops.
- `req`=4'b0101 held, source 0 sample 16'h1234, source 2 sample 16'h8000, 2 ACKs: `grant`=0001. `DACDATA`=16'h1234 twice and `sample_pop[0]` pulses twice. Then drop `req[0]`: `grant`=0100 after 2 cycles, and the next ACK gives 16'h8000.
- MAX_FRAMES=4, `req[1]` held, 5 ACKs: 3 samples loaded. The 4th ACK gives `DACDATA`=0, `timeout_err` pulse and `grant`=0. The 5th ACK gives 0. `req[1]` must go low then high again before it is re-granted.
- ACK on the same cycle `req[g]` falls: `DACDATA`=0, no pop, IDLE next cycle.
- With AUDIO_ARB_VOLUME_EN, `vol[0]`=2 and sample 16'hF000: `DACDATA`=16'hFC00.
- Reset asserted for 1 cycle mid-PLAY with a pending ACK: all outputs return to their reset values and there is no pop.
